// File: rtl/mfp_sdram_arbiter_pkg.sv
// rtl/mfp_sdram_arbiter_pkg.sv - shared command-word layout, default depths and arbiter FSM state type
package mfp_sdram_arbiter_pkg;

  localparam int SDRAM_CMD_FIFO_DATA_WIDTH = 36;
  localparam int SDRAM_TAG_DEPTH           = 4;

  localparam int CMD_ADDR_LSB  = 0;
  localparam int CMD_ADDR_MSB  = 31;
  localparam int CMD_SIZE_LSB  = 32;
  localparam int CMD_SIZE_MSB  = 34;
  localparam int CMD_WRITE_BIT = 35;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMD   = 2'd1,
    S_WDATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mfp_sdram_tag_fifo.sv
// rtl/mfp_sdram_tag_fifo.sv - register-based 1-bit tag FIFO recording which port owns each outstanding read
module mfp_sdram_tag_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        push_data,
  input  logic        pop,
  output logic        pop_data,
  output logic [AW:0] count
);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/mfp_sdram_arbiter.sv
// rtl/mfp_sdram_arbiter.sv - two-port SDRAM FIFO arbiter; SDRAM_ARB_FIXED_PRIO_EN selects fixed priority over round-robin
module mfp_sdram_arbiter
  import mfp_sdram_arbiter_pkg::*;
#(
  parameter int TAG_DEPTH = SDRAM_TAG_DEPTH,
  parameter int CMD_WIDTH = SDRAM_CMD_FIFO_DATA_WIDTH
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 REQ0,
  input  logic                 REQ1,
  input  logic [CMD_WIDTH-1:0] CMD0,
  input  logic [CMD_WIDTH-1:0] CMD1,
  input  logic [31:0]          WDATA0,
  input  logic [31:0]          WDATA1,
  output logic                 GNT0,
  output logic                 GNT1,
  output logic                 RVALID0,
  output logic                 RVALID1,
  output logic [31:0]          RDATA,
  output logic                 CFIFO_WEN,
  output logic [CMD_WIDTH-1:0] CFIFO_WDATA,
  input  logic                 CFIFO_WFULL,
  output logic                 WFIFO_WEN,
  output logic [31:0]          WFIFO_WDATA,
  input  logic                 WFIFO_WFULL,
  output logic                 RFIFO_REN,
  input  logic [31:0]          RFIFO_RDATA,
  input  logic                 RFIFO_REMPTY
);

  localparam int CW = $clog2(TAG_DEPTH);
  localparam logic [CW:0] TAG_FULL = (CW+1)'(TAG_DEPTH);

  arb_state_e           state;
  arb_state_e           state_nxt;
  logic                 winner;
  logic                 winner_nxt;
  logic                 pick;
  logic                 elig0;
  logic                 elig1;
  logic                 gnt;
  logic                 tag_push;
  logic                 tag_pop;
  logic                 tag_head;
  logic [CW:0]          tag_count;
  logic [CMD_WIDTH-1:0] cmd_sel;
  logic [31:0]          wdata_sel;

  // Writes never occupy a tag; reads wait while every tag is in flight.
  assign elig0 = REQ0 && (CMD0[CMD_WRITE_BIT] || (tag_count != TAG_FULL));
  assign elig1 = REQ1 && (CMD1[CMD_WRITE_BIT] || (tag_count != TAG_FULL));

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign pick = !elig0;
`else
  logic last_gnt;

  assign pick = (elig0 && elig1) ? ~last_gnt : elig1;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_gnt <= 1'b1;
    end else if (gnt) begin
      last_gnt <= winner;
    end
  end
`endif

  assign cmd_sel   = winner ? CMD1   : CMD0;
  assign wdata_sel = winner ? WDATA1 : WDATA0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= S_IDLE;
      winner <= 1'b0;
    end else begin
      state  <= state_nxt;
      winner <= winner_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    winner_nxt  = winner;
    gnt         = 1'b0;
    tag_push    = 1'b0;
    CFIFO_WEN   = 1'b0;
    CFIFO_WDATA = '0;
    WFIFO_WEN   = 1'b0;
    WFIFO_WDATA = '0;
    case (state)
      S_IDLE: begin
        if (elig0 || elig1) begin
          winner_nxt = pick;
          state_nxt  = S_CMD;
        end
      end
      S_CMD: begin
        if (!CFIFO_WFULL) begin
          CFIFO_WEN   = 1'b1;
          CFIFO_WDATA = cmd_sel;
          if (cmd_sel[CMD_WRITE_BIT]) begin
            state_nxt = S_WDATA;
          end else begin
            gnt       = 1'b1;
            tag_push  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_WDATA: begin
        if (!WFIFO_WFULL) begin
          WFIFO_WEN   = 1'b1;
          WFIFO_WDATA = wdata_sel;
          gnt         = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign GNT0 = gnt & ~winner;
  assign GNT1 = gnt &  winner;

  mfp_sdram_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .push      (tag_push),
    .push_data (winner),
    .pop       (tag_pop),
    .pop_data  (tag_head),
    .count     (tag_count)
  );

  // Words arriving with no read outstanding stay in the FIFO untouched.
  assign tag_pop   = !RFIFO_REMPTY && (tag_count != '0);
  assign RFIFO_REN = tag_pop;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      RVALID0 <= 1'b0;
      RVALID1 <= 1'b0;
      RDATA   <= '0;
    end else begin
      RVALID0 <= tag_pop & ~tag_head;
      RVALID1 <= tag_pop &  tag_head;
      if (tag_pop) begin
        RDATA <= RFIFO_RDATA;
      end
    end
  end

endmodule

// File: tb/tb_mfp_sdram_arbiter.sv
// tb/tb_mfp_sdram_arbiter.sv - directed and randomized bench for mfp_sdram_arbiter against a queue-based model
module tb_mfp_sdram_arbiter;

  localparam int CW    = 36;
  localparam int DEPTH = 4;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          REQ0, REQ1;
  logic [CW-1:0] CMD0, CMD1;
  logic [31:0]   WDATA0, WDATA1;
  logic          GNT0, GNT1, RVALID0, RVALID1;
  logic [31:0]   RDATA;
  logic          CFIFO_WEN;
  logic [CW-1:0] CFIFO_WDATA;
  logic          CFIFO_WFULL;
  logic          WFIFO_WEN;
  logic [31:0]   WFIFO_WDATA;
  logic          WFIFO_WFULL;
  logic          RFIFO_REN;
  logic [31:0]   RFIFO_RDATA;
  logic          RFIFO_REMPTY;

  always #5 HCLK = ~HCLK;

  mfp_sdram_arbiter dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .REQ0(REQ0), .REQ1(REQ1), .CMD0(CMD0), .CMD1(CMD1),
    .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1), .RDATA(RDATA),
    .CFIFO_WEN(CFIFO_WEN), .CFIFO_WDATA(CFIFO_WDATA), .CFIFO_WFULL(CFIFO_WFULL),
    .WFIFO_WEN(WFIFO_WEN), .WFIFO_WDATA(WFIFO_WDATA), .WFIFO_WFULL(WFIFO_WFULL),
    .RFIFO_REN(RFIFO_REN), .RFIFO_RDATA(RFIFO_RDATA), .RFIFO_REMPTY(RFIFO_REMPTY)
  );

  int tests = 0;
  int fails = 0;

  // requester and memory-side stimulus
  logic          req[2];
  logic [CW-1:0] cmd[2];
  logic [31:0]   wdata[2];
  logic          cfull = 1'b0;
  logic          wfull = 1'b0;
  logic [31:0]   rq[$];

  // transaction-level model
  bit          busy;
  bit          cmd_sent;
  int          port;
  int          last_port;
  bit          tags[$];
  bit          exp_rv0, exp_rv1;
  logic [31:0] exp_rdata;

  int obs_gnt[$];
  int obs_rv[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_port(input int i);
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    return 0;
`else
    return i % 2;
`endif
  endfunction

  task automatic drive();
    REQ0         = req[0];
    REQ1         = req[1];
    CMD0         = cmd[0];
    CMD1         = cmd[1];
    WDATA0       = wdata[0];
    WDATA1       = wdata[1];
    CFIFO_WFULL  = cfull;
    WFIFO_WFULL  = wfull;
    RFIFO_REMPTY = (rq.size() == 0);
    RFIFO_RDATA  = (rq.size() != 0) ? rq[0] : 32'h0;
  endtask

  task automatic model_reset();
    busy      = 1'b0;
    cmd_sent  = 1'b0;
    last_port = 1;
    tags.delete();
    exp_rv0   = 1'b0;
    exp_rv1   = 1'b0;
    exp_rdata = 32'h0;
  endtask

  task automatic cycle_check();
    int          eg;
    bit          ecw, eww, eren, epush, el0, el1, tv;
    logic [CW-1:0] ecd;
    logic [31:0] ewd;
    eg = -1; ecw = 0; eww = 0; epush = 0; ecd = '0; ewd = '0;
    chk("rvalid0", {63'b0, RVALID0}, {63'b0, exp_rv0});
    chk("rvalid1", {63'b0, RVALID1}, {63'b0, exp_rv1});
    if (exp_rv0 || exp_rv1) chk("rdata", {32'b0, RDATA}, {32'b0, exp_rdata});
    if (!busy) begin
      el0 = req[0] && (cmd[0][35] || tags.size() < DEPTH);
      el1 = req[1] && (cmd[1][35] || tags.size() < DEPTH);
      if (el0 || el1) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        port = el0 ? 0 : 1;
`else
        port = (el0 && el1) ? 1 - last_port : (el0 ? 0 : 1);
`endif
        busy = 1'b1;
        cmd_sent = 1'b0;
      end
    end else if (!cmd_sent) begin
      if (!cfull) begin
        ecw = 1'b1;
        ecd = cmd[port];
        if (cmd[port][35]) cmd_sent = 1'b1;
        else begin eg = port; epush = 1'b1; busy = 1'b0; end
      end
    end else if (!wfull) begin
      eww = 1'b1;
      ewd = wdata[port];
      eg = port;
      busy = 1'b0;
      cmd_sent = 1'b0;
    end
    eren = (rq.size() != 0) && (tags.size() != 0);
    chk("gnt0", {63'b0, GNT0}, {63'b0, eg == 0});
    chk("gnt1", {63'b0, GNT1}, {63'b0, eg == 1});
    chk("cfifo_wen", {63'b0, CFIFO_WEN}, {63'b0, ecw});
    if (ecw) chk("cfifo_wdata", {28'b0, CFIFO_WDATA}, {28'b0, ecd});
    chk("wfifo_wen", {63'b0, WFIFO_WEN}, {63'b0, eww});
    if (eww) chk("wfifo_wdata", {32'b0, WFIFO_WDATA}, {32'b0, ewd});
    chk("rfifo_ren", {63'b0, RFIFO_REN}, {63'b0, eren});
    exp_rv0 = 1'b0;
    exp_rv1 = 1'b0;
    if (eren) begin
      tv = tags.pop_front();
      if (tv) exp_rv1 = 1'b1; else exp_rv0 = 1'b1;
      exp_rdata = rq.pop_front();
    end
    if (epush) tags.push_back(eg == 1);
    if (eg >= 0) begin last_port = eg; req[eg] = 1'b0; end
    if (GNT0) obs_gnt.push_back(0);
    if (GNT1) obs_gnt.push_back(1);
    if (RVALID0) obs_rv.push_back(0);
    if (RVALID1) obs_rv.push_back(1);
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
    drive();
    @(negedge HCLK);
    cycle_check();
  endtask

  task automatic do_reset(input string nm);
    HRESETn = 1'b0;
    req[0] = 1'b0;
    req[1] = 1'b0;
    cfull = 1'b0;
    wfull = 1'b0;
    drive();
    model_reset();
    #1;
    chk({nm, "_gnt0"}, {63'b0, GNT0}, 64'h0);
    chk({nm, "_gnt1"}, {63'b0, GNT1}, 64'h0);
    chk({nm, "_rvalid0"}, {63'b0, RVALID0}, 64'h0);
    chk({nm, "_rvalid1"}, {63'b0, RVALID1}, 64'h0);
    chk({nm, "_rdata"}, {32'b0, RDATA}, 64'h0);
    chk({nm, "_cwen"}, {63'b0, CFIFO_WEN}, 64'h0);
    chk({nm, "_wwen"}, {63'b0, WFIFO_WEN}, 64'h0);
    chk({nm, "_ren"}, {63'b0, RFIFO_REN}, 64'h0);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
  endtask

  initial begin
    int n0, n1;
    logic [CW-1:0] tmp;
    req[0] = 0; req[1] = 0;
    cmd[0] = '0; cmd[1] = '0;
    wdata[0] = '0; wdata[1] = '0;

    do_reset("por");

    // single read, port 0
    cmd[0] = 36'h2_0000_0100;
    req[0] = 1'b1;
    step(); chk("rd0_c0_cwen", {63'b0, CFIFO_WEN}, 64'h0);
    step(); chk("rd0_c1_cwen", {63'b0, CFIFO_WEN}, 64'h1);
    chk("rd0_c1_cdata", {28'b0, CFIFO_WDATA}, 64'h2_0000_0100);
    chk("rd0_c1_gnt0", {63'b0, GNT0}, 64'h1);
    rq.push_back(32'hDEADBEEF);
    step(); chk("rd0_ren", {63'b0, RFIFO_REN}, 64'h1);
    step(); chk("rd0_rvalid0", {63'b0, RVALID0}, 64'h1);
    chk("rd0_rdata", {32'b0, RDATA}, 64'hDEADBEEF);
    chk("rd0_rvalid1", {63'b0, RVALID1}, 64'h0);

    // single write, port 1
    cmd[1] = 36'hA_0000_0200;
    wdata[1] = 32'hA5A5A5A5;
    req[1] = 1'b1;
    step(); chk("wr1_c0_cwen", {63'b0, CFIFO_WEN}, 64'h0);
    step(); chk("wr1_c1_cwen", {63'b0, CFIFO_WEN}, 64'h1);
    chk("wr1_c1_gnt1", {63'b0, GNT1}, 64'h0);
    step(); chk("wr1_c2_wwen", {63'b0, WFIFO_WEN}, 64'h1);
    chk("wr1_c2_wdata", {32'b0, WFIFO_WDATA}, 64'hA5A5A5A5);
    chk("wr1_c2_gnt1", {63'b0, GNT1}, 64'h1);

    // both ports streaming reads
    obs_gnt.delete();
    obs_rv.delete();
    cmd[0] = 36'h2_0000_0300;
    cmd[1] = 36'h2_0000_0400;
    for (int c = 0; c < 40 && obs_gnt.size() < 4; c++) begin
      req[0] = 1'b1;
      req[1] = 1'b1;
      step();
    end
    req[0] = 1'b0;
    req[1] = 1'b0;
    chk("alt_grants", obs_gnt.size(), 4);
    for (int i = 0; i < 4 && i < obs_gnt.size(); i++) chk("alt_gnt_order", obs_gnt[i], exp_port(i));
    for (int i = 1; i <= 4; i++) rq.push_back(i);
    repeat (6) step();
    chk("alt_rvalids", obs_rv.size(), 4);
    for (int i = 0; i < 4 && i < obs_rv.size(); i++) chk("alt_rv_order", obs_rv[i], exp_port(i));

    // tag queue full: write passes, read waits for a pop
    obs_gnt.delete();
    cmd[0] = 36'h2_0000_1000;
    for (int c = 0; c < 40 && obs_gnt.size() < 4; c++) begin
      if (!req[0]) req[0] = 1'b1;
      step();
    end
    chk("full_setup_grants", obs_gnt.size(), 4);
    obs_gnt.delete();
    req[0] = 1'b1;
    cmd[1] = 36'hA_0000_2000;
    wdata[1] = 32'h1357_9BDF;
    req[1] = 1'b1;
    repeat (8) step();
    n0 = 0; n1 = 0;
    foreach (obs_gnt[i]) if (obs_gnt[i] == 0) n0++; else n1++;
    chk("full_wr_granted", n1, 1);
    chk("full_rd_blocked", n0, 0);
    obs_gnt.delete();
    rq.push_back(32'h1234_5678);
    repeat (6) step();
    chk("full_rd_after_pop", obs_gnt.size(), 1);

    // reset while a write waits in the data phase with two reads pending
    do_reset("rst1");
    obs_gnt.delete();
    cmd[0] = 36'h2_0000_3000;
    for (int c = 0; c < 40 && obs_gnt.size() < 2; c++) begin
      if (!req[0]) req[0] = 1'b1;
      step();
    end
    chk("rst_setup_grants", obs_gnt.size(), 2);
    cmd[1] = 36'hA_0000_4000;
    wdata[1] = 32'h5555_AAAA;
    req[1] = 1'b1;
    wfull = 1'b1;
    repeat (3) step();
    chk("rst_stall_gnt1", {63'b0, GNT1}, 64'h0);
    do_reset("rst_wdata");
    rq.push_back(32'hCAFE_0001);
    rq.push_back(32'hCAFE_0002);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rst_no_ren", {63'b0, RFIFO_REN}, 64'h0);
    end

    // command FIFO full
    cmd[0] = 36'h2_0000_0500;
    req[0] = 1'b1;
    cfull = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("cfull_cwen", {63'b0, CFIFO_WEN}, 64'h0);
      chk("cfull_gnt0", {63'b0, GNT0}, 64'h0);
    end
    cfull = 1'b0;
    step();
    chk("cfull_drop_cwen", {63'b0, CFIFO_WEN}, 64'h1);
    chk("cfull_drop_gnt0", {63'b0, GNT0}, 64'h1);

    // write-data FIFO full
    cmd[1] = 36'hA_0000_0600;
    wdata[1] = 32'h0BAD_F00D;
    req[1] = 1'b1;
    wfull = 1'b1;
    step();
    step();
    chk("wfull_cwen", {63'b0, CFIFO_WEN}, 64'h1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("wfull_wwen", {63'b0, WFIFO_WEN}, 64'h0);
      chk("wfull_gnt1", {63'b0, GNT1}, 64'h0);
    end
    wfull = 1'b0;
    step();
    chk("wfull_drop_wwen", {63'b0, WFIFO_WEN}, 64'h1);
    chk("wfull_drop_wdata", {32'b0, WFIFO_WDATA}, 64'h0BAD_F00D);
    chk("wfull_drop_gnt1", {63'b0, GNT1}, 64'h1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req[p] && $urandom_range(0, 2) == 0) begin
          tmp[31:0]  = $urandom;
          tmp[34:32] = 3'($urandom_range(0, 7));
          tmp[35]    = 1'($urandom_range(0, 1));
          cmd[p]     = tmp;
          wdata[p]   = $urandom;
          req[p]     = 1'b1;
        end
      end
      cfull = ($urandom_range(0, 4) == 0);
      wfull = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 2) == 0 && rq.size() < 8) rq.push_back($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
